// File: rtl/panel_seq.sv
// Front-panel sequencer for the TOY machine: owns the lamps and data display,
// drives the core run/step/hold pins, and performs LOAD/LOOK through the memory RW port.
module panel_seq #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int SW    = 4,
  parameter int DRAIN = 3
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          btn_load_i,
  input  logic          btn_look_i,
  input  logic          btn_step_i,
  input  logic          btn_run_i,
  input  logic          btn_stop_i,
  input  logic          btn_enter_i,
  input  logic [AW-1:0] sw_addr_i,
  input  logic [DW-1:0] sw_data_i,
  input  logic [SW-1:0] sw_step_i,
  input  logic          brk_en_i,
  input  logic [AW-1:0] brk_addr_i,
  output logic [5:0]    btn_en_o,
  output logic          led_ready_o,
  output logic          led_inwait_o,
  output logic          led_brk_o,
  output logic          core_run_o,
  output logic          core_step_o,
  output logic          core_hold_o,
  input  logic          core_done_i,
  input  logic [AW-1:0] core_pc_i,
  input  logic          core_halt_i,
  input  logic          core_inwait_i,
  output logic          pc_wen_o,
  output logic [AW-1:0] pc_o,
  output logic          mem_val_o,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_rdy_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] disp_data_o
);

  localparam int CW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  // Lamp order {reset,stop,enter,run,step,load/look}
  localparam logic [5:0] LAMP_IDLE   = 6'b100111;
  localparam logic [5:0] LAMP_RUN    = 6'b010000;
  localparam logic [5:0] LAMP_INWAIT = 6'b101001;
  localparam logic [5:0] LAMP_HALT   = 6'b100001;

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_RUN, S_STOPPING, S_DRAIN, S_INWAIT, S_HALT, S_BRK
  } state_t;

  state_t        state_q, state_d, target_q, exit_tgt;
  logic          exit_hit, brk_hit, go_press, ls_state, run_state;
  logic          ld_acc, lk_acc, drain_rd;
  logic [AW-1:0] addr_q, base_q, last_pc_q, used_addr;
  logic          seq_q, look_pend_q, rd_pend_q;
  logic [SW-1:0] stepcnt_q;
  logic [CW-1:0] drain_cnt_q;

  // Memory handshake: a request is raised only in a cycle where mem_rdy_i is
  // already high, so every asserted mem_val_o is accepted that same cycle;
  // read data is returned on mem_rdata_i the following cycle.
  always_comb begin
    ls_state  = state_q inside {S_IDLE, S_HALT, S_BRK, S_INWAIT};
    run_state = state_q inside {S_STEP, S_RUN, S_STOPPING};
    go_press  = (state_q == S_IDLE || state_q == S_BRK) && (btn_run_i || btn_step_i);
    ld_acc    = ls_state && !go_press && btn_load_i && mem_rdy_i;
    lk_acc    = ls_state && !go_press && btn_look_i && !btn_load_i && mem_rdy_i;
    used_addr = (seq_q && sw_addr_i == base_q) ? addr_q + AW'(1) : sw_addr_i;
    drain_rd  = (state_q == S_DRAIN) && (drain_cnt_q == '0) && !rd_pend_q && mem_rdy_i;

    mem_val_o   = ld_acc || lk_acc || drain_rd;
    mem_wen_o   = ld_acc;
    mem_addr_o  = drain_rd ? last_pc_q : ((ld_acc || lk_acc) ? used_addr : '0);
    mem_wdata_o = ld_acc ? sw_data_i : '0;

    brk_hit  = brk_en_i && core_done_i && (core_pc_i == brk_addr_i);
    exit_hit = 1'b1;
    exit_tgt = S_IDLE;
    if (core_inwait_i)    exit_tgt = S_INWAIT;
    else if (core_halt_i) exit_tgt = S_HALT;
    else if (brk_hit)     exit_tgt = S_BRK;
    else                  exit_hit = 1'b0;

    state_d = state_q;
    case (state_q)
      S_IDLE, S_BRK: begin
        if (btn_run_i)                              state_d = S_RUN;
        else if (btn_step_i)                        state_d = S_STEP;
        else if (state_q == S_BRK && (ld_acc || lk_acc)) state_d = S_IDLE;
      end
      S_HALT:     if (ld_acc || lk_acc) state_d = S_IDLE;
      S_INWAIT:   if (btn_enter_i) state_d = S_IDLE;
      S_STEP: begin
        if (exit_hit)                                   state_d = S_DRAIN;
        else if (core_done_i && stepcnt_q <= SW'(1))    state_d = S_IDLE;
      end
      S_RUN: begin
        if (exit_hit)        state_d = S_DRAIN;
        else if (btn_stop_i) state_d = S_STOPPING;
      end
      S_STOPPING: begin
        if (exit_hit)         state_d = S_DRAIN;
        else if (core_done_i) state_d = S_IDLE;
      end
      S_DRAIN:    if (rd_pend_q) state_d = target_q;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= S_IDLE;
      addr_q       <= '0;
      base_q       <= '0;
      seq_q        <= 1'b0;
      stepcnt_q    <= '0;
      drain_cnt_q  <= '0;
      rd_pend_q    <= 1'b0;
      look_pend_q  <= 1'b0;
      last_pc_q    <= '0;
      btn_en_o     <= '0;
      led_ready_o  <= 1'b0;
      led_inwait_o <= 1'b0;
      led_brk_o    <= 1'b0;
      core_run_o   <= 1'b0;
      core_step_o  <= 1'b0;
      core_hold_o  <= 1'b1;
      pc_wen_o     <= 1'b0;
      pc_o         <= '0;
      disp_data_o  <= '0;
    end else begin
      state_q      <= state_d;
      core_hold_o  <= !(state_d inside {S_STEP, S_RUN, S_STOPPING});
      core_run_o   <= (state_d == S_RUN);
      led_ready_o  <= state_d inside {S_IDLE, S_HALT, S_BRK};
      led_brk_o    <= (state_d == S_BRK);
      led_inwait_o <= (state_d == S_INWAIT);
      case (state_d)
        S_IDLE, S_BRK: btn_en_o <= LAMP_IDLE;
        S_RUN:         btn_en_o <= LAMP_RUN;
        S_INWAIT:      btn_en_o <= LAMP_INWAIT;
        S_HALT:        btn_en_o <= LAMP_HALT;
        default:       btn_en_o <= '0;
      endcase

      // One instruction request on entry, then one per retirement until the count runs out
      core_step_o <= (state_d == S_STEP) &&
                     ((state_q != S_STEP) || (core_done_i && stepcnt_q > SW'(1)));
      if (state_d == S_STEP && state_q != S_STEP)
        stepcnt_q <= (sw_step_i == '0) ? SW'(1) : sw_step_i;
      else if (state_q == S_STEP && core_done_i)
        stepcnt_q <= stepcnt_q - SW'(1);

      if (run_state && core_done_i) last_pc_q <= core_pc_i;

      if (state_d == S_DRAIN && state_q != S_DRAIN) begin
        drain_cnt_q <= CW'(DRAIN);
        target_q    <= exit_tgt;
        rd_pend_q   <= 1'b0;
      end else if (state_q == S_DRAIN) begin
        if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - CW'(1);
        rd_pend_q <= drain_rd;
      end

      if (ld_acc)
        disp_data_o <= sw_data_i;
      else if (look_pend_q || (state_q == S_DRAIN && rd_pend_q))
        disp_data_o <= mem_rdata_i;
      else if (state_q == S_STEP && core_done_i)
        disp_data_o <= DW'(core_pc_i);

      look_pend_q <= lk_acc;
      pc_wen_o    <= ld_acc || lk_acc;
      // Repeated presses at an unchanged address switch walk forward through memory
      if (ld_acc || lk_acc) begin
        pc_o   <= used_addr;
        addr_q <= used_addr;
        base_q <= sw_addr_i;
        seq_q  <= 1'b1;
      end else if (!(state_d inside {S_IDLE, S_HALT, S_BRK, S_INWAIT})) begin
        seq_q <= 1'b0;
      end
    end
  end

endmodule
